hazard_controller: RTL and testbench

//  Pipeline sequencer for the 5-stage MIPS core. Decides each cycle which pipeline latches advance, hold or flush, and gates the PC.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/sat_counter.sv | 19 +
 rtl/hazard_controller.sv | 124 ++++++++++++
 tb/tb_hazard_controller.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, hazard-controller FSM states and the load-use hazard test.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDUSE   = 2'd1,
        MEMWAIT = 2'd2,
        HALT    = 2'd3
    } hz_state_t;

    // A load in EX feeds a register that ID reads; $zero never creates a dependency.
    function automatic logic lu_hazard(
        input logic     ex_dren,
        input regbits_t ex_dest,
        input regbits_t id_rs,
        input regbits_t id_rt,
        input logic     id_use_rt
    );
        return ex_dren && (ex_dest != '0) &&
               ((ex_dest == id_rs) || (id_use_rt && (ex_dest == id_rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer for the 5-stage core: per-cycle advance/hold/flush of every latch and the PC,
// plus saturating stall and redirect counters.
module hazard_controller
    import cpu_types_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int LU_CYC = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             ex_dREN,
    input  regbits_t         ex_dest,
    input  regbits_t         id_rs,
    input  regbits_t         id_rt,
    input  logic             id_useRt,
    input  logic             mem_brTaken,
    input  logic             mem_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Remaining bubbles after the first one; zero means the LDUSE state is never entered.
    localparam logic [1:0] LU_INIT = 2'(LU_CYC - 1);

    hz_state_t  state, state_n;
    logic [1:0] lu_cnt, lu_cnt_n;
    logic       lu_hit, mem_wait, redirect, stall_inc;

    assign lu_hit   = lu_hazard(ex_dREN, ex_dest, id_rs, id_rt, id_useRt);
    assign mem_wait = (mem_dREN || mem_dWEN) && !dhit;
    assign halted   = (state == HALT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= RUN;
            lu_cnt <= 2'd0;
        end else begin
            state  <= state_n;
            lu_cnt <= lu_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        lu_cnt_n    = lu_cnt;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        redirect    = 1'b0;

        if (RST) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
        end else if (state == HALT) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
        end else if (mem_halt) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            state_n = HALT;
        end else if (mem_wait) begin
            // A memory wait freezes everything; a pending bubble sequence resumes afterwards.
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            if (state != LDUSE) begin
                state_n = MEMWAIT;
            end
        end else if (mem_brTaken) begin
            {ifid_flush, idex_flush, exmem_flush} = 3'b111;
            redirect = 1'b1;
            state_n  = RUN;
            lu_cnt_n = 2'd0;
        end else if (state == LDUSE || lu_hit) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            if (state == LDUSE) begin
                lu_cnt_n = (lu_cnt == 2'd0) ? 2'd0 : lu_cnt - 2'd1;
                state_n  = (lu_cnt_n == 2'd0) ? RUN : LDUSE;
            end else begin
                lu_cnt_n = LU_INIT;
                state_n  = (LU_INIT == 2'd0) ? RUN : LDUSE;
            end
        end else begin
            if (!ihit) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
            state_n = RUN;
        end
    end

    assign stall_inc = !pc_en && !halted && !RST;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (redirect),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: three instances (LU_CYC=1, LU_CYC=3, CNT_W=4) share stimulus.
module tb_hazard_controller;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, id_useRt, mem_brTaken, mem_halt;
    logic [4:0] ex_dest, id_rs, id_rt;

    // ctl bit order: pc, ifid, idex, exmem, memwb enables, then ifid, idex, exmem flushes
    logic [2:0][7:0] ctl;
    logic [2:0]      hlt;
    logic [31:0]     a_stall, a_flush, b_stall, b_flush;
    logic [3:0]      c_stall, c_flush;

    localparam logic [7:0] NORMAL   = 8'b11111_000;
    localparam logic [7:0] RESETV   = 8'b00000_111;
    localparam logic [7:0] BUBBLE   = 8'b00111_010;
    localparam logic [7:0] STALLALL = 8'b00000_000;
    localparam logic [7:0] BRANCH   = 8'b11111_111;
    localparam logic [7:0] IFWAIT   = 8'b01111_100;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] ctl;
        logic       chk_h;
        logic       h;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    hazard_controller #(.CNT_W(32), .LU_CYC(1)) dut_a (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .ex_dREN(ex_dREN), .ex_dest(ex_dest), .id_rs(id_rs), .id_rt(id_rt), .id_useRt(id_useRt),
        .mem_brTaken(mem_brTaken), .mem_halt(mem_halt),
        .pc_en(ctl[0][7]), .ifid_en(ctl[0][6]), .idex_en(ctl[0][5]), .exmem_en(ctl[0][4]),
        .memwb_en(ctl[0][3]), .ifid_flush(ctl[0][2]), .idex_flush(ctl[0][1]), .exmem_flush(ctl[0][0]),
        .halted(hlt[0]), .stall_cnt(a_stall), .flush_cnt(a_flush)
    );

    hazard_controller #(.CNT_W(32), .LU_CYC(3)) dut_b (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .ex_dREN(ex_dREN), .ex_dest(ex_dest), .id_rs(id_rs), .id_rt(id_rt), .id_useRt(id_useRt),
        .mem_brTaken(mem_brTaken), .mem_halt(mem_halt),
        .pc_en(ctl[1][7]), .ifid_en(ctl[1][6]), .idex_en(ctl[1][5]), .exmem_en(ctl[1][4]),
        .memwb_en(ctl[1][3]), .ifid_flush(ctl[1][2]), .idex_flush(ctl[1][1]), .exmem_flush(ctl[1][0]),
        .halted(hlt[1]), .stall_cnt(b_stall), .flush_cnt(b_flush)
    );

    hazard_controller #(.CNT_W(4), .LU_CYC(1)) dut_c (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .ex_dREN(ex_dREN), .ex_dest(ex_dest), .id_rs(id_rs), .id_rt(id_rt), .id_useRt(id_useRt),
        .mem_brTaken(mem_brTaken), .mem_halt(mem_halt),
        .pc_en(ctl[2][7]), .ifid_en(ctl[2][6]), .idex_en(ctl[2][5]), .exmem_en(ctl[2][4]),
        .memwb_en(ctl[2][3]), .ifid_flush(ctl[2][2]), .idex_flush(ctl[2][1]), .exmem_flush(ctl[2][0]),
        .halted(hlt[2]), .stall_cnt(c_stall), .flush_cnt(c_flush)
    );

    task automatic set_idle();
        ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0; ex_dREN = 1'b0;
        ex_dest = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_useRt = 1'b0;
        mem_brTaken = 1'b0; mem_halt = 1'b0;
    endtask

    task automatic hazard5();
        ex_dREN = 1'b1; ex_dest = 5'd5; id_rs = 5'd5;
    endtask

    task automatic push(input string tag, input int sel, input logic [7:0] c,
                        input logic chk_h = 1'b0, input logic h = 1'b0);
        exp_t e;
        e.tag = tag; e.sel = sel; e.ctl = c; e.chk_h = chk_h; e.h = h;
        sb.push_back(e);
    endtask

    task automatic push_all(input string tag, input logic [7:0] c);
        for (int i = 0; i < 3; i++) push(tag, i, c);
    endtask

    // Compare the queued expectations mid-cycle, then move past the next rising edge.
    task automatic step();
        exp_t e;
        @(negedge CLK);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (ctl[e.sel] === e.ctl) else begin
                errors++;
                $error("FAIL %s[dut%0d] ctl got %b expected %b", e.tag, e.sel, ctl[e.sel], e.ctl);
            end
            if (e.chk_h) begin
                checks++;
                assert (hlt[e.sel] === e.h) else begin
                    errors++;
                    $error("FAIL %s[dut%0d] halted got %b expected %b", e.tag, e.sel, hlt[e.sel], e.h);
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        set_idle();
        RST = 1'b1;
        push_all("reset", RESETV);
        step();
        RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        set_idle();
        RST = 1'b1;
        push_all("rst_first", RESETV);
        step();
        push("rst_hold", 0, RESETV, 1'b1, 1'b0);
        push("rst_hold", 2, RESETV);
        step();
        RST = 1'b0;
        chk("rst_stall_a", a_stall, 32'd0);
        chk("rst_flush_a", a_flush, 32'd0);
        chk("rst_flush_c", {28'd0, c_flush}, 32'd0);
        push_all("normal", NORMAL);
        step();

        // Single-bubble and triple-bubble load-use
        hazard5();
        push_all("lu_first", BUBBLE);
        step();
        set_idle();
        push("lu_after", 0, NORMAL);
        push("lu_after", 2, NORMAL);
        push("lu3_b2", 1, BUBBLE);
        step();
        push("lu_after2", 0, NORMAL);
        push("lu3_b3", 1, BUBBLE);
        step();
        push("lu3_done", 1, NORMAL);
        step();
        chk("lu_stall_a", a_stall, 32'd1);
        chk("lu3_stall_b", b_stall, 32'd3);
        chk("lu_stall_c", {28'd0, c_stall}, 32'd1);

        do_reset();
        chk("rst2_stall_b", b_stall, 32'd0);

        // Register zero and rt-use qualification
        ex_dREN = 1'b1; ex_dest = 5'd0; id_rs = 5'd0;
        push("lu_zero", 0, NORMAL);
        step();
        ex_dest = 5'd7; id_rs = 5'd3; id_rt = 5'd7; id_useRt = 1'b0;
        push("lu_rt_unused", 0, NORMAL);
        step();
        id_useRt = 1'b1;
        push("lu_rt_used", 0, BUBBLE);
        push("lu_rt_used", 1, BUBBLE);
        step();
        set_idle();
        push("lu_rt_after", 0, NORMAL);
        push("lu_rt_b2", 1, BUBBLE);
        step();
        push("lu_rt_b3", 1, BUBBLE);
        step();
        chk("lu_rt_stall_a", a_stall, 32'd1);

        do_reset();

        // Data-memory wait with the shared port also holding off fetch
        ihit = 1'b0; mem_dREN = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push("memwait", 0, STALLALL);
            step();
        end
        dhit = 1'b1;
        push("memwait_done", 0, IFWAIT);
        step();
        set_idle();
        push("memwait_run", 0, NORMAL);
        step();
        chk("memwait_stall_a", a_stall, 32'd5);

        // Memory wait outranks a branch; the branch is honoured on the dhit cycle
        mem_dWEN = 1'b1; mem_brTaken = 1'b1;
        push("memwait_br", 0, STALLALL);
        step();
        chk("memwait_br_flush", a_flush, 32'd0);
        dhit = 1'b1;
        push("dhit_br", 0, BRANCH);
        step();
        chk("dhit_br_flush", a_flush, 32'd1);

        do_reset();

        // Branch overrides load-use
        hazard5();
        mem_brTaken = 1'b1;
        push("br_lu", 0, BRANCH);
        push("br_lu", 1, BRANCH);
        step();
        set_idle();
        push("br_next", 0, NORMAL);
        push("br_next", 1, NORMAL);
        step();
        chk("br_flush_a", a_flush, 32'd1);
        chk("br_stall_a", a_stall, 32'd0);

        // Branch cancels an LDUSE sequence in progress
        hazard5();
        push("ldu_start", 1, BUBBLE);
        step();
        set_idle();
        mem_brTaken = 1'b1;
        push("ldu_br", 1, BRANCH);
        step();
        set_idle();
        push("ldu_br_next", 1, NORMAL);
        step();
        chk("ldu_br_flush_b", b_flush, 32'd2);
        chk("ldu_br_stall_b", b_stall, 32'd1);

        // Reset aborts an LDUSE sequence
        hazard5();
        push("ldu_abort_start", 1, BUBBLE);
        step();
        set_idle();
        RST = 1'b1;
        push("ldu_abort_rst", 1, RESETV);
        step();
        RST = 1'b0;
        push("ldu_abort_after", 1, NORMAL);
        step();
        chk("ldu_abort_stall_b", b_stall, 32'd0);

        // Halt is sticky and ignores redirects until reset
        mem_halt = 1'b1;
        push("halt_enter", 0, STALLALL, 1'b1, 1'b0);
        step();
        set_idle();
        mem_brTaken = 1'b1;
        for (int i = 0; i < 100; i++) begin
            push("halt_hold", 0, STALLALL, 1'b1, 1'b1);
            step();
        end
        chk("halt_flush_a", a_flush, 32'd0);
        do_reset();
        push("halt_cleared", 0, NORMAL, 1'b1, 1'b0);
        step();
        chk("halt_rst_stall_a", a_stall, 32'd0);
        chk("halt_rst_flush_a", a_flush, 32'd0);

        // Fetch wait long enough to saturate the 4-bit counter
        ihit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            push("ifwait", 0, IFWAIT);
            push("ifwait", 2, IFWAIT);
            step();
        end
        set_idle();
        chk("sat_stall_c", {28'd0, c_stall}, 32'd15);
        chk("sat_stall_a", a_stall, 32'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
